// File: rtl/hub75_scan_driver.sv
// HUB75 64x32 scan driver: walks the panel, slices 24-bit colour into BCM bit planes,
// and sequences shift clock, latch, output enable and row select for two half-panel rows per pass.
//
// state     | meaning
// FETCH_TOP | present upper-half pixel address
// FETCH_BOT | capture upper bits, present lower-half pixel address
// SHIFT_LO  | capture lower bits, place six data bits with sclk low
// SHIFT_HI  | sclk high, advance column
// BLANK     | panel dark, update row select
// LATCH     | one-cycle latch pulse, load display timer
// DISPLAY   | panel lit for BASE_TICKS<<plane clocks
module hub75_scan_driver #(
  parameter int COLS       = 64,
  parameter int HALF_ROWS  = 16,
  parameter int PLANES     = 4,
  parameter int BASE_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] pixel_addr,
  input  logic [23:0] pixel_data,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic        r2,
  output logic        g2,
  output logic        b2,
  output logic        sclk,
  output logic        lat,
  output logic        oe_n,
  output logic [3:0]  row_addr,
  output logic        frame_start
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(HALF_ROWS);
  localparam int PW = $clog2(PLANES);

  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(HALF_ROWS - 1);
  localparam logic [PW-1:0] PLANE_LAST = PW'(PLANES - 1);

  typedef enum logic [2:0] {
    FETCH_TOP, FETCH_BOT, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] plane;
  logic [9:0]    ticks;
  logic          top_r, top_g, top_b;

  logic          col_last, plane_last, row_last, tick_tc;
  logic [4:0]    row_bot;
  logic [PLANES-1:0] r_nib, g_nib, b_nib;
  logic          unused_bits;

  logic [11:0] pixel_addr_d;
  logic        r1_d, g1_d, b1_d, r2_d, g2_d, b2_d;
  logic        sclk_d, lat_d, oe_n_d, frame_start_d;
  logic [3:0]  row_addr_d;

  assign col_last   = (col == COL_LAST);
  assign plane_last = (plane == PLANE_LAST);
  assign row_last   = (row == ROW_LAST);
  assign tick_tc    = (ticks == 10'd1);
  assign row_bot    = 5'(row) + 5'(HALF_ROWS);

  // Plane p displays channel bit 4+p of each 8-bit colour.
  assign r_nib = pixel_data[20 +: PLANES];
  assign g_nib = pixel_data[12 +: PLANES];
  assign b_nib = pixel_data[4 +: PLANES];
  assign unused_bits = ^{pixel_data[19:16], pixel_data[11:8], pixel_data[3:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH_TOP;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_TOP: state_nxt = FETCH_BOT;
      FETCH_BOT: state_nxt = SHIFT_LO;
      SHIFT_LO:  state_nxt = SHIFT_HI;
      SHIFT_HI:  state_nxt = col_last ? BLANK : FETCH_TOP;
      BLANK:     state_nxt = LATCH;
      LATCH:     state_nxt = DISPLAY;
      DISPLAY:   state_nxt = tick_tc ? FETCH_TOP : DISPLAY;
      default:   state_nxt = FETCH_TOP;
    endcase
  end

  // Outputs lag the state register by one clock, so the address register already
  // holds the address of the pixel being captured when pixel_data is sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col   <= '0;
      row   <= '0;
      plane <= '0;
      ticks <= '0;
      top_r <= 1'b0;
      top_g <= 1'b0;
      top_b <= 1'b0;
    end else begin
      case (state)
        FETCH_BOT: begin
          top_r <= r_nib[plane];
          top_g <= g_nib[plane];
          top_b <= b_nib[plane];
        end
        SHIFT_HI: col <= col_last ? '0 : col + 1'b1;
        LATCH:    ticks <= 10'(BASE_TICKS) << plane;
        DISPLAY: begin
          ticks <= ticks - 1'b1;
          if (tick_tc) begin
            if (plane_last) begin
              plane <= '0;
              row   <= row_last ? '0 : row + 1'b1;
            end else begin
              plane <= plane + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pixel_addr_d  = pixel_addr;
    r1_d          = r1;
    g1_d          = g1;
    b1_d          = b1;
    r2_d          = r2;
    g2_d          = g2;
    b2_d          = b2;
    row_addr_d    = row_addr;
    sclk_d        = 1'b0;
    lat_d         = 1'b0;
    oe_n_d        = 1'b1;
    frame_start_d = 1'b0;
    case (state)
      FETCH_TOP: begin
        pixel_addr_d  = {1'b0, 5'(row), 6'(col)};
        frame_start_d = (row == '0) && (plane == '0) && (col == '0);
      end
      FETCH_BOT: pixel_addr_d = {1'b0, row_bot, 6'(col)};
      SHIFT_LO: begin
        r1_d = top_r;
        g1_d = top_g;
        b1_d = top_b;
        r2_d = r_nib[plane];
        g2_d = g_nib[plane];
        b2_d = b_nib[plane];
      end
      SHIFT_HI: sclk_d = 1'b1;
      BLANK:    row_addr_d = 4'(row);
      LATCH:    lat_d = 1'b1;
      DISPLAY:  oe_n_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_addr  <= '0;
      r1          <= 1'b0;
      g1          <= 1'b0;
      b1          <= 1'b0;
      r2          <= 1'b0;
      g2          <= 1'b0;
      b2          <= 1'b0;
      sclk        <= 1'b0;
      lat         <= 1'b0;
      oe_n        <= 1'b1;
      row_addr    <= '0;
      frame_start <= 1'b0;
    end else begin
      pixel_addr  <= pixel_addr_d;
      r1          <= r1_d;
      g1          <= g1_d;
      b1          <= b1_d;
      r2          <= r2_d;
      g2          <= g2_d;
      b2          <= b2_d;
      sclk        <= sclk_d;
      lat         <= lat_d;
      oe_n        <= oe_n_d;
      row_addr    <= row_addr_d;
      frame_start <= frame_start_d;
    end
  end

endmodule
